// File: rtl/jam_pkg.sv
// Shared constants, types and FSM states for the JAM permutation source.
package jam_pkg;

    localparam int unsigned N_WORKERS = 8;
    localparam int unsigned JOB_W     = 3;
    localparam int unsigned IDX_W     = 16;

    typedef logic [JOB_W-1:0]     job_t;
    typedef job_t [N_WORKERS-1:0] perm_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } perm_state_e;

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation (element 0 most significant).
module jam_next_perm #(
    parameter int unsigned N     = jam_pkg::N_WORKERS,
    parameter int unsigned JOB_W = jam_pkg::JOB_W
) (
    input  logic [N-1:0][JOB_W-1:0] perm_i,
    output logic [N-1:0][JOB_W-1:0] next_o,
    output logic [JOB_W-1:0]        pivot_o,
    output logic                    is_last_o
);

    int unsigned                piv;
    int unsigned                succ;
    logic                       found;
    logic [JOB_W-1:0]           pval;
    logic [JOB_W-1:0]           sval;
    logic [N-1:0][JOB_W-1:0]    swp;

    // Variable indices are expressed as compare-and-select loops so every
    // index stays a constant after unrolling.
    always_comb begin
        found = 1'b0;
        piv   = 0;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (perm_i[i] < perm_i[i+1]) begin
                found = 1'b1;
                piv   = i;
            end
        end

        pval = '0;
        for (int unsigned m = 0; m < N; m++) begin
            if (m == piv) pval = perm_i[m];
        end

        succ = piv;
        for (int unsigned m = 0; m < N; m++) begin
            if (m > piv && perm_i[m] > pval) succ = m;
        end

        sval = '0;
        for (int unsigned m = 0; m < N; m++) begin
            if (m == succ) sval = perm_i[m];
        end

        swp = perm_i;
        for (int unsigned m = 0; m < N; m++) begin
            if (m == piv)       swp[m] = sval;
            else if (m == succ) swp[m] = pval;
        end

        next_o = swp;
        for (int unsigned k = 0; k < N; k++) begin
            if (k > piv) begin
                for (int unsigned m = 0; m < N; m++) begin
                    if (m == N + piv - k) next_o[k] = swp[m];
                end
            end
        end
        if (!found) next_o = perm_i;

        pivot_o   = JOB_W'(piv);
        is_last_o = ~found;
    end

endmodule

// File: rtl/jam_perm_gen.sv
// Enumerates all N! job assignments in lexicographic order over a valid/ready stream.
module jam_perm_gen #(
    parameter int unsigned N     = jam_pkg::N_WORKERS,
    parameter int unsigned JOB_W = jam_pkg::JOB_W,
    parameter int unsigned IDX_W = jam_pkg::IDX_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    output logic               busy,
    output logic               perm_valid,
    input  logic               perm_ready,
    output logic [N*JOB_W-1:0] perm,
    output logic               perm_first,
    output logic               perm_last,
    output logic [JOB_W-1:0]   chg_pos,
    output logic [IDX_W-1:0]   perm_idx,
    output logic               done
);
    import jam_pkg::*;

    typedef logic [N-1:0][JOB_W-1:0] arr_t;

    perm_state_e      state_q, state_d;
    arr_t             perm_q, perm_d, nxt;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [JOB_W-1:0] chg_q, chg_d, pivot;
    logic             first_q, first_d;
    logic             is_last;
    logic             hs;

    jam_next_perm #(
        .N     (N),
        .JOB_W (JOB_W)
    ) u_next (
        .perm_i    (perm_q),
        .next_o    (nxt),
        .pivot_o   (pivot),
        .is_last_o (is_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perm_q  <= '0;
            idx_q   <= '0;
            chg_q   <= '0;
            first_q <= 1'b0;
        end else begin
            perm_q  <= perm_d;
            idx_q   <= idx_d;
            chg_q   <= chg_d;
            first_q <= first_d;
        end
    end

    assign hs = perm_valid & perm_ready;

    always_comb begin
        state_d = state_q;
        perm_d  = perm_q;
        idx_d   = idx_q;
        chg_d   = chg_q;
        first_d = first_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    for (int unsigned k = 0; k < N; k++) perm_d[k] = JOB_W'(k);
                    idx_d   = '0;
                    chg_d   = '0;
                    first_d = 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    if (is_last) begin
                        state_d = FIN;
                    end else begin
                        perm_d  = nxt;
                        idx_d   = idx_q + IDX_W'(1);
                        chg_d   = pivot;
                        first_d = 1'b0;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign perm_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == FIN);
    assign perm       = perm_q;
    assign perm_idx   = idx_q;
    assign chg_pos    = chg_q;
    assign perm_first = first_q;
    // The zero perm left by reset has no pivot, so gate with valid to keep it low.
    assign perm_last  = is_last & perm_valid;

endmodule

// File: tb/tb_jam_perm_gen.sv
// Randomized-backpressure bench for jam_perm_gen against a factorial-rank reference model.
module tb_jam_perm_gen;

    logic        clk;
    logic        RST;

    logic        start8, ready8, busy8, valid8, first8, last8, done8;
    logic [23:0] perm8;
    logic [2:0]  chg8;
    logic [15:0] idx8;

    logic        start3, ready3, busy3, valid3, first3, last3, done3;
    logic [8:0]  perm3;
    logic [2:0]  chg3;
    logic [15:0] idx3;

    int n_chk = 0;
    int n_err = 0;
    bit seen[logic [23:0]];

    jam_perm_gen #(.N(8), .JOB_W(3), .IDX_W(16)) u8 (
        .CLK(clk), .RST(RST), .start(start8), .busy(busy8),
        .perm_valid(valid8), .perm_ready(ready8), .perm(perm8),
        .perm_first(first8), .perm_last(last8), .chg_pos(chg8),
        .perm_idx(idx8), .done(done8)
    );

    jam_perm_gen #(.N(3), .JOB_W(3), .IDX_W(16)) u3 (
        .CLK(clk), .RST(RST), .start(start3), .busy(busy3),
        .perm_valid(valid3), .perm_ready(ready3), .perm(perm3),
        .perm_first(first3), .perm_last(last3), .chg_pos(chg3),
        .perm_idx(idx3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Permutation with rank n, from its factorial-base digits.
    function automatic logic [23:0] perm_of(input int n, input int nn);
        int avail[$];
        int f, d, r;
        logic [23:0] res;
        res = '0;
        r = n;
        for (int i = 0; i < nn; i++) avail.push_back(i);
        for (int pos = 0; pos < nn; pos++) begin
            f = 1;
            for (int i = 1; i < nn - pos; i++) f *= i;
            d = r / f;
            r = r % f;
            res[pos*3 +: 3] = 3'(avail[d]);
            avail.delete(d);
        end
        return res;
    endfunction

    function automatic int chg_of(input logic [23:0] a, input logic [23:0] b, input int nn);
        for (int k = 0; k < nn; k++)
            if (a[k*3 +: 3] != b[k*3 +: 3]) return k;
        return 0;
    endfunction

    function automatic logic [7:0] set_mask(input logic [23:0] p);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) m[p[k*3 +: 3]] = 1'b1;
        return m;
    endfunction

    function automatic logic [8:0] pk3(input int a, input int b, input int c);
        return {3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic check_zero8(input string tag);
        check({tag, "_busy"},  busy8,  0);
        check({tag, "_valid"}, valid8, 0);
        check({tag, "_perm"},  perm8,  0);
        check({tag, "_first"}, first8, 0);
        check({tag, "_last"},  last8,  0);
        check({tag, "_chg"},   chg8,   0);
        check({tag, "_idx"},   idx8,   0);
        check({tag, "_done"},  done8,  0);
    endtask

    // Runs the N=8 instance from start; stop_at<0 runs to completion.
    task automatic run8(input int stop_at);
        int          exp_idx, ec, hs, hold;
        bit          fin, lastacc;
        logic [23:0] mp, pp;
        exp_idx = 0; ec = 0; hs = 0; hold = 0; fin = 0; lastacc = 0;
        mp = perm_of(0, 8);
        seen.delete();
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        for (int cyc = 0; cyc < 50000 && !fin; cyc++) begin
            check("valid8", valid8, 1);
            check("busy8",  busy8,  1);
            check("done8",  done8,  0);
            check("idx8",   idx8,   exp_idx);
            check("perm8",  perm8,  mp);
            check("chg8",   chg8,   ec);
            check("first8", first8, exp_idx == 0);
            check("last8",  last8,  exp_idx == 40319);
            check("set8",   set_mask(perm8), 8'hff);
            if (stop_at >= 0 && exp_idx == stop_at) begin
                start8 = 1'b0;
                return;
            end
            if (exp_idx == 100) begin
                ready8 = (hold >= 5);
                hold++;
            end else if (exp_idx < 1000) begin
                ready8 = ($urandom_range(3) != 0);
            end else begin
                ready8 = 1'b1;
            end
            start8 = (exp_idx == 200);
            if (ready8) begin
                check("dup8", seen.exists(perm8), 0);
                seen[perm8] = 1'b1;
                hs++;
                if (exp_idx == 40319) lastacc = 1'b1;
                else begin
                    pp = mp;
                    exp_idx++;
                    mp = perm_of(exp_idx, 8);
                    ec = chg_of(pp, mp, 8);
                end
            end
            @(negedge clk);
            if (lastacc) begin
                check("fin_valid8", valid8, 0);
                check("fin_done8",  done8,  1);
                check("fin_busy8",  busy8,  0);
                check("fin_perm8",  perm8,  mp);
                @(negedge clk);
                check("post_done8", done8, 0);
                check("post_busy8", busy8, 0);
                fin = 1'b1;
            end
        end
        start8 = 1'b0;
        check("run8_end", fin, 1);
        check("hs_count8", hs, 40320);
    endtask

    task automatic run3();
        logic [8:0] tbl[6];
        int         chg[6];
        tbl[0] = pk3(0, 1, 2); tbl[1] = pk3(0, 2, 1); tbl[2] = pk3(1, 0, 2);
        tbl[3] = pk3(1, 2, 0); tbl[4] = pk3(2, 0, 1); tbl[5] = pk3(2, 1, 0);
        chg[0] = 0; chg[1] = 1; chg[2] = 0; chg[3] = 1; chg[4] = 0; chg[5] = 1;
        ready3 = 1'b1;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("valid3", valid3, 1);
            check("perm3",  perm3,  tbl[i]);
            check("chg3",   chg3,   chg[i]);
            check("idx3",   idx3,   i);
            check("first3", first3, i == 0);
            check("last3",  last3,  i == 5);
            @(negedge clk);
        end
        check("fin_done3",  done3,  1);
        check("fin_valid3", valid3, 0);
        @(negedge clk);
        check("post_done3", done3, 0);
    endtask

    initial begin
        RST = 1'b1;
        start8 = 1'b0; ready8 = 1'b0;
        start3 = 1'b0; ready3 = 1'b0;
        #1 RST = 1'b0;
        #2 check_zero8("rst0");
        check("rst0_last3", last3, 0);
        repeat (2) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);

        run8(500);
        #2 RST = 1'b0;
        #1 check_zero8("rst_mid");
        @(negedge clk); RST = 1'b1;
        @(negedge clk);
        check("no_done8", done8, 0);
        check("idle_valid8", valid8, 0);

        run8(-1);
        run3();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/jam_perm_gen.md
Name: jam_perm_gen

Overview:
Permutation source for the JAM job-assignment engine. It enumerates every assignment of N jobs to N workers in lexicographic order. A valid/ready handshake feeds these assignments to the cost-accumulate stage directly downstream. Each permutation carries the lowest changed index, so the consumer only re-sums the costs of the changed suffix.

Parameters:
N, 8, number of workers/jobs; legal range 2..8
JOB_W, 3, bits per job index; must satisfy 2**JOB_W >= N
IDX_W, 16, width of the permutation counter; must hold N!-1

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset (0 = reset)
start  in  1  one-cycle pulse; begins enumeration when idle
busy  out  1  high from the cycle after an accepted start until done
perm_valid  out  1  perm and sidebands are valid
perm_ready  in  1  consumer accepts the current permutation
perm  out  N*JOB_W  job of worker k is at bits [k*JOB_W +: JOB_W]
perm_first  out  1  current permutation is the identity (index 0)
perm_last  out  1  current permutation is fully descending (index N!-1)
chg_pos  out  JOB_W  lowest worker index differing from the previous permutation; 0 on first
perm_idx  out  IDX_W  ordinal of the current permutation
done  out  1  one-cycle pulse after the last permutation is accepted

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, perm = all zeros, FSM = IDLE. Reset mid-run aborts the enumeration immediately; no done pulse is issued.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1:
  - next cycle: RUN, busy=1, perm_valid=1, perm[k]=k, perm_first=1, perm_idx=0, chg_pos=0.
  - start is ignored in RUN and FIN.
- RUN, handshake = perm_valid & perm_ready:
  - No handshake: perm, perm_idx, chg_pos, perm_first and perm_last hold stable.
  - Handshake, perm_last=0: next cycle loads next_perm; perm_idx+1; chg_pos=pivot; perm_first=0. perm_valid stays 1, giving one permutation per cycle under perm_ready=1.
  - Handshake, perm_last=1: next cycle perm_valid=0, state FIN.
- FIN: done=1 for exactly one cycle, busy=0, next state IDLE. perm keeps its last value.
- perm_last is combinational from the registered perm: high when no pivot exists (strictly descending).
- next_perm, computed from the registered perm (element 0 is most significant):
  - pivot i = largest i in 0..N-2 with p[i] < p[i+1];
  - successor j = largest j > i with p[j] > p[i];
  - swap p[i] and p[j], then reverse p[i+1..N-1].
  - All of this is combinational within one cycle.
- Arithmetic: all comparisons are unsigned on JOB_W bits. perm_idx increments without saturation; wrap cannot occur because N!-1 fits in IDX_W.
- Simultaneous start and handshake cannot occur: start is only honoured in IDLE, where perm_valid=0.
- Elements never duplicate. Each perm is a permutation of 0..N-1 (checked by assertion).

Decomposition:
- Package jam_pkg holds:
  - constants N_WORKERS=8, JOB_W=3, IDX_W=16;
  - typedef job_t (logic [JOB_W-1:0]) and perm_t (job_t [N_WORKERS]);
  - enum perm_state_e {IDLE, RUN, FIN}.
- Sub-module jam_next_perm is purely combinational:
  - input perm_t;
  - outputs next perm_t, pivot (JOB_W bits), is_last.
- jam_perm_gen keeps the FSM, registers and handshake.

Test Plan:
- N=8, start, perm_ready=1 → cycle+1: perm=0,1,2,3,4,5,6,7, first=1, idx=0, chg_pos=0. cycle+2: 0,1,2,3,4,5,7,6, chg_pos=6. cycle+3: 0,1,2,3,4,6,5,7, chg_pos=5.
- N=8, full run with perm_ready=1:
  - perm_last=1 at idx 40319 with perm 7,6,5,4,3,2,1,0;
  - done one cycle after that accept;
  - exactly 40320 handshakes, all distinct (scoreboard);
  - the chg_pos suffix always matches the reference model.
- Backpressure: drop perm_ready for 5 cycles at idx 100 → perm, idx and chg_pos stable across those cycles; idx 101 appears one cycle after ready returns.
- N=3 → sequence 012, 021, 102, 120, 201, 210 with chg_pos 0, 1, 0, 1, 0, 1; done after the 6th handshake.
- Reset and start interaction:
  - RST=0 at idx 500 → all outputs 0 asynchronously;
  - start after release restarts at idx 0 with identity;
  - a start pulse while busy=1 has no effect on idx.
